// File: rtl/ysyx22041405_lsu_bus.sv
// Load/store unit between EX and WB: one op at a time, lane-aligns stores onto the
// XLEN-wide bus, extracts/extends load data, and passes non-memory ops through.
module ysyx22041405_lsu_bus #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_load,
  input  logic            in_is_store,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [XLEN-1:0] in_result,
  input  logic [4:0]      in_rd,
  input  logic            in_rf_we,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_we,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wmask,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_wdata,
  output logic [4:0]      out_rd,
  output logic            out_rf_we,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_misalign,
  output logic [1:0]      dbg_state
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the valid side holds its payload stable until that edge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic            req_we_q, req_we_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] req_wdata_q, req_wdata_d;
  logic [NB-1:0]   req_wmask_q, req_wmask_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [XLEN-1:0] out_wdata_q, out_wdata_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic            out_rf_we_q, out_rf_we_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [31:0]     out_inst_q, out_inst_d;
  logic            out_misalign_q, out_misalign_d;

  logic [OFFW-1:0] off;
  int              bytes;
  int              bits;
  logic            is_mem;
  logic            is_st;
  logic            misal;
  logic [NB-1:0]   base_mask;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] ld_data;
  logic            ext;

  // Byte-lane mask and load extraction are size-driven; a size wider than the bus
  // simply copies the whole beat (only reachable when it was already flagged).
  always_comb begin
    off       = in_addr[OFFW-1:0];
    bytes     = 1 << in_size;
    is_mem    = in_is_load | in_is_store;
    is_st     = in_is_store & ~in_is_load;
    misal     = ((int'(off) & (bytes - 1)) != 0) || (in_size == 2'd3 && XLEN == 32);
    base_mask = '0;
    for (int i = 0; i < NB; i++) base_mask[i] = (i < bytes);

    sh   = mem_resp_rdata >> {off_q, 3'b000};
    bits = 8 << size_q;
    ext  = 1'b0;
    for (int i = 0; i < XLEN; i++) if (i == bits - 1) ext = sh[i] & ~uns_q;
    ld_data = '0;
    for (int i = 0; i < XLEN; i++) ld_data[i] = (i < bits) ? sh[i] : ext;
  end

  always_comb begin
    state_d        = state_q;
    req_we_d       = req_we_q;
    req_addr_d     = req_addr_q;
    req_wdata_d    = req_wdata_q;
    req_wmask_d    = req_wmask_q;
    size_d         = size_q;
    uns_d          = uns_q;
    off_d          = off_q;
    out_wdata_d    = out_wdata_q;
    out_rd_d       = out_rd_q;
    out_rf_we_d    = out_rf_we_q;
    out_pc_d       = out_pc_q;
    out_inst_d     = out_inst_q;
    out_misalign_d = out_misalign_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          size_d         = in_size;
          uns_d          = in_unsigned;
          off_d          = off;
          out_rd_d       = in_rd;
          out_pc_d       = in_pc;
          out_inst_d     = in_inst;
          out_wdata_d    = in_result;
          out_rf_we_d    = in_rf_we;
          out_misalign_d = 1'b0;
          if (!is_mem) begin
            state_d = DONE;
          end else if (misal) begin
            out_misalign_d = 1'b1;
            out_rf_we_d    = 1'b0;
            state_d        = DONE;
          end else begin
            req_we_d    = is_st;
            req_addr_d  = in_addr & ~{{(XLEN-OFFW){1'b0}}, {OFFW{1'b1}}};
            req_wdata_d = in_wdata << {off, 3'b000};
            req_wmask_d = is_st ? (base_mask << off) : '0;
            if (is_st) out_rf_we_d = 1'b0;
            state_d     = REQ;
          end
        end
      end
      REQ:  if (mem_req_ready) state_d = RESP;
      RESP: begin
        if (mem_resp_valid) begin
          if (!req_we_q) out_wdata_d = ld_data;
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      req_we_q       <= 1'b0;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
      req_wmask_q    <= '0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      off_q          <= '0;
      out_wdata_q    <= '0;
      out_rd_q       <= '0;
      out_rf_we_q    <= 1'b0;
      out_pc_q       <= '0;
      out_inst_q     <= '0;
      out_misalign_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_we_q       <= req_we_d;
      req_addr_q     <= req_addr_d;
      req_wdata_q    <= req_wdata_d;
      req_wmask_q    <= req_wmask_d;
      size_q         <= size_d;
      uns_q          <= uns_d;
      off_q          <= off_d;
      out_wdata_q    <= out_wdata_d;
      out_rd_q       <= out_rd_d;
      out_rf_we_q    <= out_rf_we_d;
      out_pc_q       <= out_pc_d;
      out_inst_q     <= out_inst_d;
      out_misalign_q <= out_misalign_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign out_valid     = (state_q == DONE);
  assign mem_req_we    = req_we_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wmask = req_wmask_q;
  assign out_wdata     = out_wdata_q;
  assign out_rd        = out_rd_q;
  assign out_rf_we     = out_rf_we_q;
  assign out_pc        = out_pc_q;
  assign out_inst      = out_inst_q;
  assign out_misalign  = out_misalign_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ysyx22041405_lsu_bus.sv
// Directed bench for ysyx22041405_lsu_bus: one XLEN=32 and one XLEN=64 instance,
// inputs driven and outputs sampled on the falling clock edge.
module tb_ysyx22041405_lsu_bus;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // XLEN=32 instance
  logic        in_valid, in_ready, in_is_load, in_is_store, in_unsigned, in_rf_we;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata, in_result, in_pc, in_inst;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
  logic [3:0]  mem_req_wmask;
  logic        out_valid, out_ready, out_rf_we, out_misalign;
  logic [31:0] out_wdata, out_pc, out_inst;
  logic [4:0]  out_rd;
  logic [1:0]  dbg_state;

  // XLEN=64 instance
  logic        w_in_valid, w_in_ready, w_in_is_load, w_in_is_store, w_in_unsigned, w_in_rf_we;
  logic [1:0]  w_in_size;
  logic [63:0] w_in_addr, w_in_wdata, w_in_result, w_in_pc;
  logic [31:0] w_in_inst;
  logic [4:0]  w_in_rd;
  logic        w_mem_req_valid, w_mem_req_ready, w_mem_req_we, w_mem_resp_valid;
  logic [63:0] w_mem_req_addr, w_mem_req_wdata, w_mem_resp_rdata;
  logic [7:0]  w_mem_req_wmask;
  logic        w_out_valid, w_out_ready, w_out_rf_we, w_out_misalign;
  logic [63:0] w_out_wdata, w_out_pc;
  logic [31:0] w_out_inst;
  logic [4:0]  w_out_rd;
  logic [1:0]  w_dbg_state;

  ysyx22041405_lsu_bus #(.XLEN(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_result(in_result), .in_rd(in_rd), .in_rf_we(in_rf_we), .in_pc(in_pc),
    .in_inst(in_inst), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_wdata(out_wdata), .out_rd(out_rd), .out_rf_we(out_rf_we), .out_pc(out_pc),
    .out_inst(out_inst), .out_misalign(out_misalign), .dbg_state(dbg_state)
  );

  ysyx22041405_lsu_bus #(.XLEN(64)) u64 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_is_load(w_in_is_load), .in_is_store(w_in_is_store), .in_size(w_in_size),
    .in_unsigned(w_in_unsigned), .in_addr(w_in_addr), .in_wdata(w_in_wdata),
    .in_result(w_in_result), .in_rd(w_in_rd), .in_rf_we(w_in_rf_we), .in_pc(w_in_pc),
    .in_inst(w_in_inst), .mem_req_valid(w_mem_req_valid), .mem_req_ready(w_mem_req_ready),
    .mem_req_we(w_mem_req_we), .mem_req_addr(w_mem_req_addr), .mem_req_wdata(w_mem_req_wdata),
    .mem_req_wmask(w_mem_req_wmask), .mem_resp_valid(w_mem_resp_valid),
    .mem_resp_rdata(w_mem_resp_rdata), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_wdata(w_out_wdata), .out_rd(w_out_rd), .out_rf_we(w_out_rf_we), .out_pc(w_out_pc),
    .out_inst(w_out_inst), .out_misalign(w_out_misalign), .dbg_state(w_dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int req_xfers = 0;

  always @(posedge clk) if (!rst && mem_req_valid && mem_req_ready) req_xfers++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one op for a single cycle; returns at the falling edge of cycle N+1.
  task automatic issue32(input logic ld, input logic st, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] result, input logic [4:0] rd,
                         input logic rf_we, input logic [31:0] pc);
    in_is_load = ld; in_is_store = st; in_size = size; in_unsigned = uns;
    in_addr = addr; in_wdata = wdata; in_result = result; in_rd = rd;
    in_rf_we = rf_we; in_pc = pc; in_inst = 32'h0000_0013;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic issue64(input logic ld, input logic st, input logic [1:0] size,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] result);
    w_in_is_load = ld; w_in_is_store = st; w_in_size = size; w_in_unsigned = 1'b0;
    w_in_addr = addr; w_in_wdata = wdata; w_in_result = result; w_in_rd = 5'd11;
    w_in_rf_we = 1'b1; w_in_pc = 64'h1000; w_in_inst = 32'h0000_0013;
    w_in_valid = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b0;
  endtask

  task automatic run_load32(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic [31:0] exp_data);
    issue32(1'b1, 1'b0, size, uns, addr, 32'h0, 32'h0, 5'd7, 1'b1, 32'h180);
    check_eq({tag, "_req_valid"}, mem_req_valid, 1'b1);
    check_eq({tag, "_req_we"}, mem_req_we, 1'b0);
    check_eq({tag, "_req_wmask"}, mem_req_wmask, 4'b0000);
    check_eq({tag, "_req_addr"}, mem_req_addr, exp_addr);
    @(negedge clk);
    check_eq({tag, "_early_out"}, out_valid, 1'b0);
    mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check_eq({tag, "_out_valid"}, out_valid, 1'b1);
    check_eq({tag, "_out_wdata"}, out_wdata, exp_data);
    check_eq({tag, "_out_rf_we"}, out_rf_we, 1'b1);
    check_eq({tag, "_out_rd"}, out_rd, 5'd7);
    check_eq({tag, "_misalign"}, out_misalign, 1'b0);
    @(negedge clk);
  endtask

  task automatic run_misalign32(input string tag, input logic [31:0] addr, input logic [1:0] size);
    int x0;
    x0 = req_xfers;
    issue32(1'b1, 1'b0, size, 1'b0, addr, 32'h0, 32'h0, 5'd8, 1'b1, 32'h1C0);
    check_eq({tag, "_out_valid"}, out_valid, 1'b1);
    check_eq({tag, "_misalign"}, out_misalign, 1'b1);
    check_eq({tag, "_rf_we"}, out_rf_we, 1'b0);
    check_eq({tag, "_req_valid"}, mem_req_valid, 1'b0);
    @(negedge clk);
    check_eq({tag, "_in_ready"}, in_ready, 1'b1);
    check_eq({tag, "_no_xfer"}, 64'(req_xfers - x0), 64'd0);
  endtask

  initial begin
    int x0;
    rst = 1'b1;
    in_valid = 0; in_is_load = 0; in_is_store = 0; in_size = 0; in_unsigned = 0;
    in_addr = 0; in_wdata = 0; in_result = 0; in_rd = 0; in_rf_we = 0; in_pc = 0; in_inst = 0;
    mem_req_ready = 1; mem_resp_valid = 0; mem_resp_rdata = 0; out_ready = 1;
    w_in_valid = 0; w_in_is_load = 0; w_in_is_store = 0; w_in_size = 0; w_in_unsigned = 0;
    w_in_addr = 0; w_in_wdata = 0; w_in_result = 0; w_in_rd = 0; w_in_rf_we = 0;
    w_in_pc = 0; w_in_inst = 0;
    w_mem_req_ready = 1; w_mem_resp_valid = 0; w_mem_resp_rdata = 0; w_out_ready = 1;

    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_req_valid", mem_req_valid, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_misalign", out_misalign, 1'b0);
    check_eq("rst_req_addr", mem_req_addr, 32'h0);
    check_eq("rst_req_wmask", mem_req_wmask, 4'h0);
    check_eq("rst_out_wdata", out_wdata, 32'h0);
    check_eq("rst_state", dbg_state, 2'd0);
    check_eq("rst_w_out_valid", w_out_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // store byte at 0x80000003
    issue32(1'b0, 1'b1, 2'd0, 1'b0, 32'h8000_0003, 32'h0000_00AB, 32'h0, 5'd3, 1'b1, 32'h100);
    check_eq("stb_req_valid", mem_req_valid, 1'b1);
    check_eq("stb_req_addr", mem_req_addr, 32'h8000_0000);
    check_eq("stb_req_wmask", mem_req_wmask, 4'b1000);
    check_eq("stb_req_wdata", mem_req_wdata, 32'hAB00_0000);
    check_eq("stb_req_we", mem_req_we, 1'b1);
    check_eq("stb_in_ready", in_ready, 1'b0);
    @(negedge clk);
    check_eq("stb_req_drop", mem_req_valid, 1'b0);
    mem_resp_valid = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check_eq("stb_out_valid", out_valid, 1'b1);
    check_eq("stb_out_rf_we", out_rf_we, 1'b0);
    check_eq("stb_out_pc", out_pc, 32'h100);
    @(negedge clk);
    check_eq("stb_idle", in_ready, 1'b1);
    check_eq("stb_out_drop", out_valid, 1'b0);

    run_load32("lh_s", 32'h8000_0002, 2'd1, 1'b0, 32'h8001_1234, 32'h8000_0000, 32'hFFFF_8001);
    run_load32("lh_u", 32'h8000_0002, 2'd1, 1'b1, 32'h8001_1234, 32'h8000_0000, 32'h0000_8001);
    run_load32("lb_s", 32'h8000_0001, 2'd0, 1'b0, 32'h1122_F344, 32'h8000_0000, 32'hFFFF_FFF3);
    run_load32("lw",   32'h8000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h8000_0004, 32'hDEAD_BEEF);

    run_misalign32("mis_w", 32'h8000_0002, 2'd2);
    run_misalign32("mis_d", 32'h8000_0000, 2'd3);

    // pass-through
    issue32(1'b0, 1'b0, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'h0000_1234, 5'd9, 1'b1, 32'h200);
    check_eq("pt_out_valid", out_valid, 1'b1);
    check_eq("pt_out_wdata", out_wdata, 32'h0000_1234);
    check_eq("pt_out_rd", out_rd, 5'd9);
    check_eq("pt_out_rf_we", out_rf_we, 1'b1);
    check_eq("pt_misalign", out_misalign, 1'b0);
    check_eq("pt_req_valid", mem_req_valid, 1'b0);
    @(negedge clk);

    // backpressure on all three handshakes: store half at 0x80000002
    mem_req_ready = 1'b0;
    x0 = req_xfers;
    issue32(1'b0, 1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 5'd4, 1'b1, 32'h300);
    for (int k = 1; k <= 4; k++) begin
      check_eq("bp_req_valid", mem_req_valid, 1'b1);
      check_eq("bp_req_addr", mem_req_addr, 32'h8000_0000);
      check_eq("bp_req_wmask", mem_req_wmask, 4'b1100);
      check_eq("bp_req_wdata", mem_req_wdata, 32'hBEEF_0000);
      check_eq("bp_req_we", mem_req_we, 1'b1);
      if (k == 4) mem_req_ready = 1'b1;
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    check_eq("bp_resp_wait", mem_req_valid, 1'b0);
    @(negedge clk);
    check_eq("bp_n6_out", out_valid, 1'b0);
    @(negedge clk);
    check_eq("bp_n7_out", out_valid, 1'b0);
    mem_resp_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    for (int k = 8; k <= 10; k++) begin
      check_eq("bp_out_valid", out_valid, 1'b1);
      check_eq("bp_out_rf_we", out_rf_we, 1'b0);
      check_eq("bp_out_rd", out_rd, 5'd4);
      check_eq("bp_out_pc", out_pc, 32'h300);
      if (k == 10) out_ready = 1'b1;
      @(negedge clk);
    end
    check_eq("bp_out_drop", out_valid, 1'b0);
    check_eq("bp_in_ready", in_ready, 1'b1);
    check_eq("bp_one_xfer", 64'(req_xfers - x0), 64'd1);
    mem_req_ready = 1'b1;

    // reset while waiting for the response
    issue32(1'b1, 1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 5'd2, 1'b1, 32'h400);
    @(negedge clk);
    check_eq("rr_in_resp", dbg_state, 2'd2);
    rst = 1'b1;
    #1;
    check_eq("rr_out_valid", out_valid, 1'b0);
    check_eq("rr_req_valid", mem_req_valid, 1'b0);
    check_eq("rr_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check_eq("rr_stray_out", out_valid, 1'b0);
    check_eq("rr_stray_ready", in_ready, 1'b1);
    check_eq("rr_stray_wdata", out_wdata, 32'h0);

    // XLEN=64: load word at offset 4
    issue64(1'b1, 1'b0, 2'd2, 64'h0000_0000_8000_0004, 64'h0, 64'h0);
    check_eq("w_lw_req_valid", w_mem_req_valid, 1'b1);
    check_eq("w_lw_req_addr", w_mem_req_addr, 64'h0000_0000_8000_0000);
    check_eq("w_lw_req_wmask", w_mem_req_wmask, 8'h00);
    @(negedge clk);
    w_mem_resp_valid = 1'b1; w_mem_resp_rdata = 64'h8765_4321_0000_0000;
    @(negedge clk);
    w_mem_resp_valid = 1'b0;
    check_eq("w_lw_out_valid", w_out_valid, 1'b1);
    check_eq("w_lw_out_wdata", w_out_wdata, 64'hFFFF_FFFF_8765_4321);
    @(negedge clk);

    // XLEN=64: store word at offset 4
    issue64(1'b0, 1'b1, 2'd2, 64'h0000_0000_8000_0004, 64'h0000_0000_CAFE_F00D, 64'h0);
    check_eq("w_sw_req_wmask", w_mem_req_wmask, 8'hF0);
    check_eq("w_sw_req_wdata", w_mem_req_wdata, 64'hCAFE_F00D_0000_0000);
    check_eq("w_sw_req_we", w_mem_req_we, 1'b1);
    @(negedge clk);
    w_mem_resp_valid = 1'b1;
    @(negedge clk);
    w_mem_resp_valid = 1'b0;
    check_eq("w_sw_out_valid", w_out_valid, 1'b1);
    check_eq("w_sw_out_rf_we", w_out_rf_we, 1'b0);
    @(negedge clk);

    // XLEN=64: pass-through
    issue64(1'b0, 1'b0, 2'd0, 64'h0, 64'h0, 64'h0000_0000_0000_1234);
    check_eq("w_pt_out_valid", w_out_valid, 1'b1);
    check_eq("w_pt_out_wdata", w_out_wdata, 64'h1234);
    check_eq("w_pt_out_rf_we", w_out_rf_we, 1'b1);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
